// File: rtl/softmax_pkg.sv
// Shared definitions for the softmax sequencer slice.
//   IDX_W  : width of a score / exp_lut index
//   EXP_W  : width of a Q4.4 exp value
//   OUT_W  : width of a Q0.8 probability
//   NUM_W  : width of the divider numerator ({exp, 8'h00})
//   sm_state_t : controller FSM states
//   clog2  : ceiling log2, usable in constant expressions
package softmax_pkg;

    localparam int unsigned IDX_W  = 6;
    localparam int unsigned EXP_W  = 8;
    localparam int unsigned OUT_W  = 8;
    localparam int unsigned Q_FRAC = 4;
    localparam int unsigned NUM_W  = EXP_W + OUT_W;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        DIV,
        OUT
    } sm_state_t;

    function automatic int unsigned clog2(input int unsigned value);
        int unsigned res;
        int unsigned pow;
        res = 0;
        pow = 1;
        while (pow < value) begin
            pow = pow << 1;
            res = res + 1;
        end
        return res;
    endfunction

endpackage

// File: rtl/softmax_seq_ctrl_if.sv
// Score input stream and probability output stream of the softmax sequencer.
//   in_valid/in_ready/in_score     : score stream (producer -> sequencer)
//   res_valid/res_ready/res_data/res_last : result stream (sequencer -> consumer)
// Modports: master = the environment (producer + consumer), slave = the sequencer.
interface softmax_seq_ctrl_if;
    import softmax_pkg::*;

    logic             in_valid;
    logic             in_ready;
    logic [IDX_W-1:0] in_score;
    logic             res_valid;
    logic             res_ready;
    logic [OUT_W-1:0] res_data;
    logic             res_last;

    modport master (
        output in_valid, in_score, res_ready,
        input  in_ready, res_valid, res_data, res_last
    );

    modport slave (
        input  in_valid, in_score, res_ready,
        output in_ready, res_valid, res_data, res_last
    );

endinterface

// File: rtl/exp_lut.sv
// Exponential lookup: exp_val = round(16 * e^((idx - 16) / 16)) in Q4.4.
//   idx     in  6  table index; 0..31 valid, 32..63 return 0
//   exp_val out 8  Q4.4 exp value
module exp_lut
    import softmax_pkg::*;
(
    input  logic [IDX_W-1:0] idx,
    output logic [EXP_W-1:0] exp_val
);

    always_comb begin
        exp_val = '0;
        if (!idx[IDX_W-1]) begin
            case (idx[4:0])
                5'd0:  exp_val = 8'd6;
                5'd1:  exp_val = 8'd6;
                5'd2:  exp_val = 8'd7;
                5'd3:  exp_val = 8'd7;
                5'd4:  exp_val = 8'd8;
                5'd5:  exp_val = 8'd8;
                5'd6:  exp_val = 8'd9;
                5'd7:  exp_val = 8'd9;
                5'd8:  exp_val = 8'd10;
                5'd9:  exp_val = 8'd10;
                5'd10: exp_val = 8'd11;
                5'd11: exp_val = 8'd12;
                5'd12: exp_val = 8'd12;
                5'd13: exp_val = 8'd13;
                5'd14: exp_val = 8'd14;
                5'd15: exp_val = 8'd15;
                5'd16: exp_val = 8'd16;
                5'd17: exp_val = 8'd17;
                5'd18: exp_val = 8'd18;
                5'd19: exp_val = 8'd19;
                5'd20: exp_val = 8'd21;
                5'd21: exp_val = 8'd22;
                5'd22: exp_val = 8'd23;
                5'd23: exp_val = 8'd25;
                5'd24: exp_val = 8'd26;
                5'd25: exp_val = 8'd28;
                5'd26: exp_val = 8'd30;
                5'd27: exp_val = 8'd32;
                5'd28: exp_val = 8'd34;
                5'd29: exp_val = 8'd36;
                5'd30: exp_val = 8'd38;
                default: exp_val = 8'd41;
            endcase
        end
    end

endmodule

// File: rtl/softmax_div_serial.sv
// Serial restoring divider, one quotient bit per cycle.
//   clk, rst     clock, synchronous active-high reset
//   start   in   load operands and perform the first step in the same cycle
//   num     in   NUM_W-bit numerator
//   den     in   SUM_W-bit divisor
//   active  out  division in progress (start to done inclusive)
//   done    out  last step finished; quo/div_by_zero valid
//   quo     out  OUT_W-bit quotient, saturated to all-ones
//   div_by_zero out  divisor was zero (quo forced to 0)
module softmax_div_serial
    import softmax_pkg::*;
#(
    parameter int unsigned SUM_W   = 10,
    parameter int unsigned DIV_CYC = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [NUM_W-1:0] num,
    input  logic [SUM_W-1:0] den,
    output logic             active,
    output logic             done,
    output logic [OUT_W-1:0] quo,
    output logic             div_by_zero
);

    localparam int unsigned CNT_W = clog2(DIV_CYC + 1);

    logic             active_q;
    logic [CNT_W-1:0] cnt_q;
    logic [SUM_W-1:0] rem_q;
    logic [NUM_W-1:0] num_q;
    logic [NUM_W-1:0] quo_q;
    logic [SUM_W-1:0] den_q;

    logic [SUM_W-1:0] rem_in;
    logic [NUM_W-1:0] num_in;
    logic [NUM_W-1:0] quo_in;
    logic [SUM_W-1:0] den_in;
    logic [SUM_W:0]   trial;
    logic             fits;
    logic [SUM_W-1:0] rem_nx;

    // On start the first step works directly on the incoming operands so the
    // whole division spans exactly DIV_CYC cycles.
    always_comb begin
        rem_in = start ? '0  : rem_q;
        num_in = start ? num : num_q;
        quo_in = start ? '0  : quo_q;
        den_in = start ? den : den_q;
        trial  = {rem_in, num_in[NUM_W-1]};
        fits   = trial >= {1'b0, den_in};
        rem_nx = fits ? SUM_W'(trial - {1'b0, den_in}) : trial[SUM_W-1:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            active_q <= 1'b0;
            cnt_q    <= '0;
            rem_q    <= '0;
            num_q    <= '0;
            quo_q    <= '0;
            den_q    <= '0;
        end else if (start) begin
            active_q <= 1'b1;
            cnt_q    <= CNT_W'(DIV_CYC - 1);
            rem_q    <= rem_nx;
            num_q    <= {num_in[NUM_W-2:0], 1'b0};
            quo_q    <= {quo_in[NUM_W-2:0], fits};
            den_q    <= den_in;
        end else if (active_q) begin
            if (cnt_q != '0) begin
                cnt_q <= cnt_q - 1'b1;
                rem_q <= rem_nx;
                num_q <= {num_in[NUM_W-2:0], 1'b0};
                quo_q <= {quo_in[NUM_W-2:0], fits};
            end else begin
                active_q <= 1'b0;
            end
        end
    end

    assign active      = active_q;
    assign done        = active_q && (cnt_q == '0);
    assign div_by_zero = (den_q == '0);

    always_comb begin
        if (div_by_zero) begin
            quo = '0;
        end else if (|quo_q[NUM_W-1:OUT_W]) begin
            quo = '1;
        end else begin
            quo = quo_q[OUT_W-1:0];
        end
    end

endmodule

// File: rtl/softmax_seq_ctrl.sv
// Time-multiplexed softmax sequencer. Collects N scores, looks each up in
// exp_lut, buffers the exps and their sum, then divides each exp by the sum
// serially and streams the Q0.8 results out in input order.
//   clk, rst  clock, synchronous active-high reset
//   bus       softmax_seq_ctrl_if.slave: score input and result output streams
//   busy      high whenever the FSM is not IDLE
//   sum_zero  sticky: last vector's exp sum was 0; cleared on next vector's first accept
module softmax_seq_ctrl
    import softmax_pkg::*;
#(
    parameter int unsigned N       = 4,
    parameter int unsigned DIV_CYC = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    softmax_seq_ctrl_if.slave        bus,
    output logic                     busy,
    output logic                     sum_zero
);

    localparam int unsigned SUM_W = EXP_W + clog2(N);
    localparam int unsigned CNT_W = (N > 1) ? clog2(N) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(N - 1);

    sm_state_t        state_q, state_d;
    logic [CNT_W-1:0] idx_q, idx_d;
    logic [CNT_W-1:0] elem_q, elem_d;
    logic [SUM_W-1:0] sum_q, sum_d;
    logic [OUT_W-1:0] q_q, q_d;
    logic             sum_zero_q, sum_zero_d;
    logic [EXP_W-1:0] exp_buf_q [N];

    logic [EXP_W-1:0] lut_exp;
    logic             accept;
    logic             div_start;
    logic             div_active;
    logic             div_done;
    logic [OUT_W-1:0] div_quo;
    logic             div_zero;
    logic [NUM_W-1:0] div_num;

    exp_lut u_exp_lut (
        .idx     (bus.in_score),
        .exp_val (lut_exp)
    );

    assign div_num = {exp_buf_q[elem_q], {OUT_W{1'b0}}};

    softmax_div_serial #(
        .SUM_W   (SUM_W),
        .DIV_CYC (DIV_CYC)
    ) u_div (
        .clk         (clk),
        .rst         (rst),
        .start       (div_start),
        .num         (div_num),
        .den         (sum_q),
        .active      (div_active),
        .done        (div_done),
        .quo         (div_quo),
        .div_by_zero (div_zero)
    );

    // in_ready is held low while rst is asserted so it only rises once reset is released.
    assign bus.in_ready = !rst && ((state_q == IDLE) || (state_q == LOAD));
    assign accept       = bus.in_valid && bus.in_ready;

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        elem_d     = elem_q;
        sum_d      = sum_q;
        q_d        = q_q;
        sum_zero_d = sum_zero_q;
        div_start  = 1'b0;
        case (state_q)
            IDLE, LOAD: begin
                if (accept) begin
                    sum_d = sum_q + SUM_W'(lut_exp);
                    if (state_q == IDLE) begin
                        sum_zero_d = 1'b0;
                    end
                    if (idx_q == LAST) begin
                        state_d = DIV;
                        idx_d   = '0;
                        elem_d  = '0;
                    end else begin
                        state_d = LOAD;
                        idx_d   = idx_q + 1'b1;
                    end
                end
            end
            DIV: begin
                // Kick the divider once per element; it stays active until done.
                div_start = !div_active;
                if (div_done) begin
                    state_d = OUT;
                    q_d     = div_quo;
                    if (div_zero) begin
                        sum_zero_d = 1'b1;
                    end
                end
            end
            OUT: begin
                if (bus.res_ready) begin
                    if (elem_q == LAST) begin
                        state_d = IDLE;
                        sum_d   = '0;
                        idx_d   = '0;
                        elem_d  = '0;
                    end else begin
                        state_d = DIV;
                        elem_d  = elem_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            idx_q      <= '0;
            elem_q     <= '0;
            sum_q      <= '0;
            q_q        <= '0;
            sum_zero_q <= 1'b0;
            for (int unsigned i = 0; i < N; i++) begin
                exp_buf_q[i] <= '0;
            end
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            elem_q     <= elem_d;
            sum_q      <= sum_d;
            q_q        <= q_d;
            sum_zero_q <= sum_zero_d;
            if (accept) begin
                exp_buf_q[idx_q] <= lut_exp;
            end
        end
    end

    assign bus.res_valid = (state_q == OUT);
    assign bus.res_data  = (state_q == OUT) ? q_q : '0;
    assign bus.res_last  = (state_q == OUT) && (elem_q == LAST);
    assign busy          = (state_q != IDLE);
    assign sum_zero      = sum_zero_q;

endmodule

// File: tb/tb_softmax_seq_ctrl.sv
// Self-checking bench for softmax_seq_ctrl: directed vectors, backpressure,
// mid-operation reset and randomized vectors against a real-arithmetic model.
module tb_softmax_seq_ctrl;
    import softmax_pkg::*;

    localparam int NV = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic busy;
    logic sum_zero;

    softmax_seq_ctrl_if bus ();

    softmax_seq_ctrl #(
        .N       (NV),
        .DIV_CYC (16)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus),
        .busy     (busy),
        .sum_zero (sum_zero)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail   = 0;

    int         vec      [NV];
    logic [7:0] got_data [NV];
    logic       got_last [NV];
    int         lat      [NV];
    int         last_hs;
    int         tmo;
    int         stall_err;
    int         inrdy_err;

    // Reference: exp value straight from its definition, softmax with floor and clamp.
    function automatic int exp_ref(input int s);
        if (s >= 32) return 0;
        return $rtoi(16.0 * $exp(real'(s - 16) / 16.0) + 0.5);
    endfunction

    function automatic int sm_ref(input int e, input int sum);
        int q;
        if (sum == 0) return 0;
        q = (e * 256) / sum;
        return (q > 255) ? 255 : q;
    endfunction

    task automatic clear_errs();
        tmo = 0;
        stall_err = 0;
        inrdy_err = 0;
    endtask

    // Drives vec[] as NV beats with up to max_gap idle cycles before each beat.
    task automatic send_vector(input int max_gap);
        int guard;
        int gap;
        for (int i = 0; i < NV; i++) begin
            gap = (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0;
            bus.in_valid = 1'b0;
            for (int g = 0; g < gap; g++) @(negedge clk);
            bus.in_valid = 1'b1;
            bus.in_score = 6'(vec[i]);
            guard = 0;
            while (bus.in_ready !== 1'b1 && guard < 50) begin
                @(negedge clk);
                guard++;
            end
            if (guard >= 50) tmo++;
            @(negedge clk);
            last_hs = cyc;
        end
        bus.in_valid = 1'b0;
    endtask

    // Collects cnt results, stalling each for 'stall' cycles; records data,
    // last flag and latency from the previous handshake.
    task automatic recv_results(input int cnt, input int stall);
        int guard;
        for (int k = 0; k < cnt; k++) begin
            guard = 0;
            while (bus.res_valid !== 1'b1 && guard < 100) begin
                if (bus.in_ready !== 1'b0) inrdy_err++;
                @(negedge clk);
                guard++;
            end
            if (guard >= 100) tmo++;
            lat[k]      = cyc - last_hs;
            got_data[k] = bus.res_data;
            got_last[k] = bus.res_last;
            bus.res_ready = 1'b0;
            for (int s = 0; s < stall; s++) begin
                @(negedge clk);
                if (bus.res_valid !== 1'b1 || bus.res_data !== got_data[k] ||
                    bus.res_last !== got_last[k] || bus.in_ready !== 1'b0) stall_err++;
            end
            bus.res_ready = 1'b1;
            @(negedge clk);
            last_hs = cyc;
            bus.res_ready = 1'b0;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        n_checks++;
        if (bus.res_valid !== 1'b0 || bus.res_data !== 8'd0 || bus.res_last !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_res: valid=%b data=%0d last=%b required 0/0/0",
                     bus.res_valid, bus.res_data, bus.res_last);
        end
        n_checks++;
        if (busy !== 1'b0 || sum_zero !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_flags: busy=%b sum_zero=%b required 0/0", busy, sum_zero);
        end
        n_checks++;
        if (bus.in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_in_ready_during: got %b required 0", bus.in_ready);
        end
        rst = 1'b0;
        @(negedge clk);
        n_checks++;
        if (bus.in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_in_ready_after: got %b required 1", bus.in_ready);
        end
    endtask

    task automatic test_directed();
        int dir_sc  [5][NV];
        int dir_res [5][NV];
        int dir_sz  [5];
        dir_sc  = '{'{16, 16, 16, 16}, '{0, 16, 31, 8}, '{40, 40, 40, 16},
                    '{40, 50, 63, 32}, '{16, 16, 16, 16}};
        dir_res = '{'{64, 64, 64, 64}, '{21, 56, 143, 35}, '{0, 0, 0, 255},
                    '{0, 0, 0, 0}, '{64, 64, 64, 64}};
        dir_sz  = '{0, 0, 0, 1, 0};
        for (int v = 0; v < 5; v++) begin
            clear_errs();
            for (int i = 0; i < NV; i++) vec[i] = dir_sc[v][i];
            send_vector(0);
            recv_results(NV, 0);
            for (int k = 0; k < NV; k++) begin
                n_checks++;
                if (int'(got_data[k]) !== dir_res[v][k]) begin
                    n_fail++;
                    $display("FAIL directed%0d_data[%0d]: got %0d required %0d",
                             v, k, got_data[k], dir_res[v][k]);
                end
                n_checks++;
                if (got_last[k] !== (k == NV - 1)) begin
                    n_fail++;
                    $display("FAIL directed%0d_last[%0d]: got %b required %b",
                             v, k, got_last[k], (k == NV - 1));
                end
                n_checks++;
                if (lat[k] !== 17) begin
                    n_fail++;
                    $display("FAIL directed%0d_latency[%0d]: got %0d required 17", v, k, lat[k]);
                end
            end
            n_checks++;
            if (int'(sum_zero) !== dir_sz[v]) begin
                n_fail++;
                $display("FAIL directed%0d_sum_zero: got %b required %0d", v, sum_zero, dir_sz[v]);
            end
            n_checks++;
            if (tmo !== 0 || inrdy_err !== 0 || busy !== 1'b0) begin
                n_fail++;
                $display("FAIL directed%0d_protocol: timeouts=%0d in_ready_errs=%0d busy=%b required 0/0/0",
                         v, tmo, inrdy_err, busy);
            end
        end
    endtask

    task automatic test_backpressure();
        int expd [NV];
        expd = '{21, 56, 143, 35};
        clear_errs();
        vec = '{0, 16, 31, 8};
        send_vector(0);
        recv_results(NV, 5);
        for (int k = 0; k < NV; k++) begin
            n_checks++;
            if (int'(got_data[k]) !== expd[k] || got_last[k] !== (k == NV - 1)) begin
                n_fail++;
                $display("FAIL stall_data[%0d]: got %0d/%b required %0d/%b",
                         k, got_data[k], got_last[k], expd[k], (k == NV - 1));
            end
        end
        n_checks++;
        if (lat[0] !== 17) begin
            n_fail++;
            $display("FAIL stall_first_latency: got %0d required 17", lat[0]);
        end
        n_checks++;
        if (stall_err !== 0 || inrdy_err !== 0 || tmo !== 0) begin
            n_fail++;
            $display("FAIL stall_stability: unstable=%0d in_ready_errs=%0d timeouts=%0d required 0/0/0",
                     stall_err, inrdy_err, tmo);
        end
    endtask

    task automatic test_reset_mid();
        clear_errs();
        vec = '{0, 16, 31, 8};
        send_vector(0);
        recv_results(2, 0);
        repeat (5) @(negedge clk);
        n_checks++;
        if (busy !== 1'b1 || bus.res_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL midrst_in_div: busy=%b res_valid=%b required 1/0", busy, bus.res_valid);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        n_checks++;
        if (bus.res_valid !== 1'b0 || bus.res_data !== 8'd0 || bus.res_last !== 1'b0 ||
            busy !== 1'b0 || sum_zero !== 1'b0 || bus.in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL midrst_outputs: valid=%b data=%0d last=%b busy=%b sz=%b in_ready=%b required 0/0/0/0/0/1",
                     bus.res_valid, bus.res_data, bus.res_last, busy, sum_zero, bus.in_ready);
        end
        @(negedge clk);
        vec = '{16, 16, 16, 16};
        send_vector(0);
        recv_results(NV, 0);
        for (int k = 0; k < NV; k++) begin
            n_checks++;
            if (got_data[k] !== 8'd64 || got_last[k] !== (k == NV - 1)) begin
                n_fail++;
                $display("FAIL midrst_after[%0d]: got %0d/%b required 64/%b",
                         k, got_data[k], got_last[k], (k == NV - 1));
            end
        end
        n_checks++;
        if (tmo !== 0) begin
            n_fail++;
            $display("FAIL midrst_timeout: got %0d timeouts required 0", tmo);
        end
    endtask

    task automatic test_random();
        int exps [NV];
        int sum;
        int stall;
        for (int v = 0; v < 10; v++) begin
            clear_errs();
            sum = 0;
            for (int i = 0; i < NV; i++) begin
                vec[i]  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(32, 63))
                                                      : int'($urandom_range(0, 31));
                exps[i] = exp_ref(vec[i]);
                sum += exps[i];
            end
            stall = int'($urandom_range(0, 3));
            send_vector(2);
            recv_results(NV, stall);
            for (int k = 0; k < NV; k++) begin
                n_checks++;
                if (int'(got_data[k]) !== sm_ref(exps[k], sum) || got_last[k] !== (k == NV - 1)) begin
                    n_fail++;
                    $display("FAIL random%0d[%0d] score=%0d sum=%0d: got %0d/%b required %0d/%b",
                             v, k, vec[k], sum, got_data[k], got_last[k],
                             sm_ref(exps[k], sum), (k == NV - 1));
                end
                n_checks++;
                if (lat[k] !== 17) begin
                    n_fail++;
                    $display("FAIL random%0d_latency[%0d]: got %0d required 17", v, k, lat[k]);
                end
            end
            n_checks++;
            if (sum_zero !== (sum == 0) || tmo !== 0 || stall_err !== 0 || inrdy_err !== 0) begin
                n_fail++;
                $display("FAIL random%0d_status: sum_zero=%b timeouts=%0d unstable=%0d in_ready_errs=%0d required %b/0/0/0",
                         v, sum_zero, tmo, stall_err, inrdy_err, (sum == 0));
            end
        end
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_score  = '0;
        bus.res_ready = 1'b0;
        last_hs = 0;
        clear_errs();
        test_reset();
        test_directed();
        test_backpressure();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
